// File: rtl/tbus_arbiter.sv
// -----------------------------------------------------------------------------
// tbus_arbiter
//
// Shares one downstream trinity-bus (tbus) master port between two masters:
// the LSU data channel (port 0) and the instruction-fetch channel (port 1).
// The arbiter accepts one request at a time and latches it into holding
// registers. It drives that request downstream, then routes the completion
// pulse and read data back to the owning requester only.
//
// Configuration macro: TBUS_ARB_RR_EN
//   defined   -> round-robin between the two ports when both request
//   undefined -> fixed priority, LSU over IFU (no pointer state)
//
// Ports
//   clock, reset                 single clock, synchronous active-high reset
//   lsu_index_valid/ready        LSU request handshake
//   lsu_index, lsu_write_data,
//   lsu_write_mask,
//   lsu_operation_type           LSU request payload
//   lsu_read_data,
//   lsu_operation_done           LSU completion (one-cycle pulse + data)
//   ifu_index_valid/ready        IFU request handshake (read-only port)
//   ifu_index                    IFU address
//   ifu_read_data,
//   ifu_operation_done           IFU completion
//   ifu_flush                    redirect: discard a pending IFU completion
//   tbus_*                       downstream tbus master port
//   arb_busy                     high whenever the FSM is not IDLE
//   dbg_state                    current FSM state (0 IDLE, 1 REQ, 2 RESP)
//
// Handshake semantics: a request transfers on a cycle where valid and ready
// are both high. The requester holds valid and payload stable until then.
// The *_index_ready outputs are combinational and are raised only in IDLE,
// for the single winner. Downstream, tbus_index_valid stays high with a
// stable payload until tbus_index_ready.
// -----------------------------------------------------------------------------

`ifndef TBUS_RANGE
`define TBUS_RANGE 0:0
`endif
`ifndef TBUS_READ
`define TBUS_READ 1'b0
`endif
`ifndef TBUS_WRITE
`define TBUS_WRITE 1'b1
`endif

module tbus_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              lsu_index_valid,
    output logic              lsu_index_ready,
    input  logic [ADDR_W-1:0] lsu_index,
    input  logic [DATA_W-1:0] lsu_write_data,
    input  logic [DATA_W-1:0] lsu_write_mask,
    input  logic [`TBUS_RANGE] lsu_operation_type,
    output logic [DATA_W-1:0] lsu_read_data,
    output logic              lsu_operation_done,

    input  logic              ifu_index_valid,
    output logic              ifu_index_ready,
    input  logic [ADDR_W-1:0] ifu_index,
    output logic [DATA_W-1:0] ifu_read_data,
    output logic              ifu_operation_done,
    input  logic              ifu_flush,

    output logic              tbus_index_valid,
    input  logic              tbus_index_ready,
    output logic [ADDR_W-1:0] tbus_index,
    output logic [DATA_W-1:0] tbus_write_data,
    output logic [DATA_W-1:0] tbus_write_mask,
    output logic [`TBUS_RANGE] tbus_operation_type,
    input  logic [DATA_W-1:0] tbus_read_data,
    input  logic              tbus_operation_done,

    output logic              arb_busy,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic OWN_LSU = 1'b0;
    localparam logic OWN_IFU = 1'b1;

    state_e             state_q, state_d;
    logic               owner_q, owner_d;
    logic               drop_q, drop_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  wmask_q, wmask_d;
    logic [`TBUS_RANGE] op_q, op_d;

    logic grant_lsu;
    logic grant_ifu;
    logic done_fire;

    // ---------------------------------------------------------------------
    // Winner selection (meaningful only while IDLE)
    // ---------------------------------------------------------------------
`ifdef TBUS_ARB_RR_EN
    // Records whether the most recent grant went to the IFU. It resets to 1
    // so that the first contested grant goes to the LSU.
    logic rr_last_ifu_q, rr_last_ifu_d;

    always_comb begin
        grant_lsu = lsu_index_valid && (!ifu_index_valid || rr_last_ifu_q);
        grant_ifu = ifu_index_valid && !grant_lsu;
    end

    always_comb begin
        rr_last_ifu_d = rr_last_ifu_q;
        if (state_q == ST_IDLE && (grant_lsu || grant_ifu)) begin
            rr_last_ifu_d = grant_ifu;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_last_ifu_q <= 1'b1;
        end else begin
            rr_last_ifu_q <= rr_last_ifu_d;
        end
    end
`else
    always_comb begin
        grant_lsu = lsu_index_valid;
        grant_ifu = ifu_index_valid && !lsu_index_valid;
    end
`endif

    // ---------------------------------------------------------------------
    // FSM next-state and handshake outputs
    // ---------------------------------------------------------------------
    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
        drop_d           = drop_q;
        idx_d            = idx_q;
        wdata_d          = wdata_q;
        wmask_d          = wmask_q;
        op_d             = op_q;
        lsu_index_ready  = 1'b0;
        ifu_index_ready  = 1'b0;
        tbus_index_valid = 1'b0;
        done_fire        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (grant_lsu) begin
                    lsu_index_ready = 1'b1;
                    idx_d           = lsu_index;
                    wdata_d         = lsu_write_data;
                    wmask_d         = lsu_write_mask;
                    op_d            = lsu_operation_type;
                    owner_d         = OWN_LSU;
                    state_d         = ST_REQ;
                end else if (grant_ifu) begin
                    ifu_index_ready = 1'b1;
                    idx_d           = ifu_index;
                    wdata_d         = '0;
                    wmask_d         = '0;
                    op_d            = `TBUS_READ;
                    owner_d         = OWN_IFU;
                    state_d         = ST_REQ;
                end
            end
            ST_REQ: begin
                tbus_index_valid = 1'b1;
                if (tbus_index_ready) begin
                    // Memory may answer in the same cycle as it accepts.
                    if (tbus_operation_done) begin
                        done_fire = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        state_d   = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (tbus_operation_done) begin
                    done_fire = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A redirect while the IFU owns the bus only hides the completion.
        // The downstream transaction always runs to its end.
        if (state_q != ST_IDLE && owner_q == OWN_IFU && ifu_flush) begin
            drop_d = 1'b1;
        end
        if (state_d == ST_IDLE) begin
            drop_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_LSU;
            drop_q  <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            drop_q  <= drop_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            op_q    <= op_d;
        end
    end

    // ---------------------------------------------------------------------
    // Downstream payload and completion routing
    // ---------------------------------------------------------------------
    logic lsu_done_int;
    logic ifu_done_int;

    // A flush that arrives in the completion cycle itself also discards it.
    assign lsu_done_int = done_fire && (owner_q == OWN_LSU);
    assign ifu_done_int = done_fire && (owner_q == OWN_IFU) && !drop_q && !ifu_flush;

    assign tbus_index          = idx_q;
    assign tbus_write_data     = wdata_q;
    assign tbus_write_mask     = wmask_q;
    assign tbus_operation_type = op_q;

    assign lsu_operation_done = lsu_done_int;
    assign ifu_operation_done = ifu_done_int;
    assign lsu_read_data      = lsu_done_int ? tbus_read_data : '0;
    assign ifu_read_data      = ifu_done_int ? tbus_read_data : '0;

    assign arb_busy  = (state_q != ST_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_tbus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tbus_arbiter
//
// Directed bench for tbus_arbiter. Inputs are driven 1 time unit after the
// rising clock edge. Outputs are sampled 1 time unit later, well away from
// the active edge. The grant order under contention is tracked with an
// expected-owner queue.
// -----------------------------------------------------------------------------

module tb_tbus_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // ---------------- DUT signals ----------------
    logic          lsu_index_valid = 1'b0;
    logic          lsu_index_ready;
    logic [AW-1:0] lsu_index = '0;
    logic [DW-1:0] lsu_write_data = '0;
    logic [DW-1:0] lsu_write_mask = '0;
    logic          lsu_operation_type = OP_RD;
    logic [DW-1:0] lsu_read_data;
    logic          lsu_operation_done;
    logic          ifu_index_valid = 1'b0;
    logic          ifu_index_ready;
    logic [AW-1:0] ifu_index = '0;
    logic [DW-1:0] ifu_read_data;
    logic          ifu_operation_done;
    logic          ifu_flush = 1'b0;
    logic          tbus_index_valid;
    logic          tbus_index_ready = 1'b0;
    logic [AW-1:0] tbus_index;
    logic [DW-1:0] tbus_write_data;
    logic [DW-1:0] tbus_write_mask;
    logic          tbus_operation_type;
    logic [DW-1:0] tbus_read_data = '0;
    logic          tbus_operation_done = 1'b0;
    logic          arb_busy;
    logic [1:0]    dbg_state;

    tbus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock               (clock),
        .reset               (reset),
        .lsu_index_valid     (lsu_index_valid),
        .lsu_index_ready     (lsu_index_ready),
        .lsu_index           (lsu_index),
        .lsu_write_data      (lsu_write_data),
        .lsu_write_mask      (lsu_write_mask),
        .lsu_operation_type  (lsu_operation_type),
        .lsu_read_data       (lsu_read_data),
        .lsu_operation_done  (lsu_operation_done),
        .ifu_index_valid     (ifu_index_valid),
        .ifu_index_ready     (ifu_index_ready),
        .ifu_index           (ifu_index),
        .ifu_read_data       (ifu_read_data),
        .ifu_operation_done  (ifu_operation_done),
        .ifu_flush           (ifu_flush),
        .tbus_index_valid    (tbus_index_valid),
        .tbus_index_ready    (tbus_index_ready),
        .tbus_index          (tbus_index),
        .tbus_write_data     (tbus_write_data),
        .tbus_write_mask     (tbus_write_mask),
        .tbus_operation_type (tbus_operation_type),
        .tbus_read_data      (tbus_read_data),
        .tbus_operation_done (tbus_operation_done),
        .arb_busy            (arb_busy),
        .dbg_state           (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [0:0] exp_q[$];   // expected grant owner: 0 LSU, 1 IFU

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance to just after the next rising edge; inputs are driven here.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Let combinational outputs settle before sampling.
    task automatic settle();
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_busy"}, {63'd0, arb_busy}, 64'd0);
        check_eq({tag, "_state"}, {62'd0, dbg_state}, 64'd0);
        check_eq({tag, "_tvalid"}, {63'd0, tbus_index_valid}, 64'd0);
        check_eq({tag, "_ldone"}, {63'd0, lsu_operation_done}, 64'd0);
        check_eq({tag, "_idone"}, {63'd0, ifu_operation_done}, 64'd0);
    endtask

    // One contested round: both ports valid. The winner is accepted in IDLE
    // and completed with a same-cycle downstream ready+done.
    task automatic contested_round(input int rnd);
        logic [0:0] w;
        logic [63:0] data;
        w = exp_q.pop_front();
        data = 64'h1000 + 64'(rnd);
        settle();
        check_eq($sformatf("rr%0d_lrdy", rnd), {63'd0, lsu_index_ready}, {63'd0, ~w});
        check_eq($sformatf("rr%0d_irdy", rnd), {63'd0, ifu_index_ready}, {63'd0, w});
        cyc();
        tbus_index_ready    = 1'b1;
        tbus_operation_done = 1'b1;
        tbus_read_data      = data;
        settle();
        check_eq($sformatf("rr%0d_tidx", rnd), tbus_index, w ? ifu_index : lsu_index);
        check_eq($sformatf("rr%0d_ldone", rnd), {63'd0, lsu_operation_done}, {63'd0, ~w});
        check_eq($sformatf("rr%0d_idone", rnd), {63'd0, ifu_operation_done}, {63'd0, w});
        check_eq($sformatf("rr%0d_ldata", rnd), lsu_read_data, w ? 64'd0 : data);
        check_eq($sformatf("rr%0d_idata", rnd), ifu_read_data, w ? data : 64'd0);
        check_eq($sformatf("rr%0d_nordy", rnd), {62'd0, lsu_index_ready, ifu_index_ready}, 64'd0);
        cyc();
        tbus_index_ready    = 1'b0;
        tbus_operation_done = 1'b0;
        tbus_read_data      = '0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        // reset state
        reset = 1'b1;
        repeat (3) cyc();
        settle();
        check_idle_outputs("rst");
        check_eq("rst_tidx", tbus_index, 64'd0);
        check_eq("rst_twdata", tbus_write_data, 64'd0);
        check_eq("rst_rdy", {62'd0, lsu_index_ready, ifu_index_ready}, 64'd0);
        reset = 1'b0;
        cyc();

        // ---- single LSU read ----
        lsu_index_valid    = 1'b1;
        lsu_index          = 64'h8000_1000;
        lsu_operation_type = OP_RD;
        settle();
        check_eq("rd_c0_lrdy", {63'd0, lsu_index_ready}, 64'd1);
        check_eq("rd_c0_irdy", {63'd0, ifu_index_ready}, 64'd0);
        check_eq("rd_c0_tvalid", {63'd0, tbus_index_valid}, 64'd0);
        cyc();
        lsu_index_valid = 1'b0;
        settle();
        check_eq("rd_c1_tvalid", {63'd0, tbus_index_valid}, 64'd1);
        check_eq("rd_c1_tidx", tbus_index, 64'h8000_1000);
        check_eq("rd_c1_top", {63'd0, tbus_operation_type}, {63'd0, OP_RD});
        cyc();
        tbus_index_ready = 1'b1;
        settle();
        check_eq("rd_c2_tvalid", {63'd0, tbus_index_valid}, 64'd1);
        cyc();
        tbus_index_ready = 1'b0;
        settle();
        check_eq("rd_c3_tvalid", {63'd0, tbus_index_valid}, 64'd0);
        check_eq("rd_c3_busy", {63'd0, arb_busy}, 64'd1);
        check_eq("rd_c3_ldone", {63'd0, lsu_operation_done}, 64'd0);
        cyc();
        tbus_operation_done = 1'b1;
        tbus_read_data      = 64'hDEAD_BEEF;
        settle();
        check_eq("rd_c4_ldone", {63'd0, lsu_operation_done}, 64'd1);
        check_eq("rd_c4_ldata", lsu_read_data, 64'hDEAD_BEEF);
        check_eq("rd_c4_idone", {63'd0, ifu_operation_done}, 64'd0);
        check_eq("rd_c4_idata", ifu_read_data, 64'd0);
        cyc();
        tbus_operation_done = 1'b0;
        tbus_read_data      = '0;
        settle();
        check_idle_outputs("rd_c5");

        // ---- LSU store, 3 stall cycles, then same-cycle ready+done ----
        lsu_index_valid    = 1'b1;
        lsu_index          = 64'h40;
        lsu_write_data     = 64'h1234;
        lsu_write_mask     = 64'hFF;
        lsu_operation_type = OP_WR;
        settle();
        check_eq("st_lrdy", {63'd0, lsu_index_ready}, 64'd1);
        cyc();
        // Scramble the source to show the downstream view comes from holding regs.
        lsu_index_valid    = 1'b0;
        lsu_write_data     = 64'h5555;
        lsu_write_mask     = 64'h0;
        lsu_operation_type = OP_RD;
        for (int i = 0; i < 3; i++) begin
            settle();
            check_eq($sformatf("st_stall%0d_tvalid", i), {63'd0, tbus_index_valid}, 64'd1);
            check_eq($sformatf("st_stall%0d_top", i), {63'd0, tbus_operation_type}, {63'd0, OP_WR});
            check_eq($sformatf("st_stall%0d_mask", i), tbus_write_mask, 64'hFF);
            check_eq($sformatf("st_stall%0d_data", i), tbus_write_data, 64'h1234);
            cyc();
        end
        tbus_index_ready    = 1'b1;
        tbus_operation_done = 1'b1;
        settle();
        check_eq("st_same_data", tbus_write_data, 64'h1234);
        check_eq("st_same_ldone", {63'd0, lsu_operation_done}, 64'd1);
        cyc();
        tbus_index_ready    = 1'b0;
        tbus_operation_done = 1'b0;
        settle();
        check_idle_outputs("st_after");

        // ---- contention: both ports valid across three transactions ----
`ifdef TBUS_ARB_RR_EN
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
`else
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b0);
`endif
        lsu_index          = 64'hA000;
        lsu_operation_type = OP_RD;
        ifu_index          = 64'hB000;
        lsu_index_valid    = 1'b1;
        ifu_index_valid    = 1'b1;
        for (int r = 0; r < 3; r++) begin
            contested_round(r);
        end
        lsu_index_valid = 1'b0;
        ifu_index_valid = 1'b0;
        check_eq("rr_queue_empty", 64'(exp_q.size()), 64'd0);
        cyc();

        // ---- IFU read with flush in RESP ----
        ifu_index_valid = 1'b1;
        ifu_index       = 64'h2000;
        settle();
        check_eq("fl_irdy", {63'd0, ifu_index_ready}, 64'd1);
        cyc();
        ifu_index_valid  = 1'b0;
        tbus_index_ready = 1'b1;
        settle();
        check_eq("fl_top", {63'd0, tbus_operation_type}, {63'd0, OP_RD});
        check_eq("fl_tidx", tbus_index, 64'h2000);
        cyc();
        tbus_index_ready = 1'b0;
        ifu_flush        = 1'b1;
        settle();
        check_eq("fl_state_resp", {62'd0, dbg_state}, 64'd2);
        cyc();
        ifu_flush           = 1'b0;
        tbus_operation_done = 1'b1;
        tbus_read_data      = 64'hCAFE;
        lsu_index_valid     = 1'b1;
        lsu_index           = 64'h3000;
        settle();
        check_eq("fl_idone", {63'd0, ifu_operation_done}, 64'd0);
        check_eq("fl_idata", ifu_read_data, 64'd0);
        check_eq("fl_ldone", {63'd0, lsu_operation_done}, 64'd0);
        check_eq("fl_lrdy_busy", {63'd0, lsu_index_ready}, 64'd0);
        cyc();
        tbus_operation_done = 1'b0;
        tbus_read_data      = '0;
        settle();
        check_eq("fl_next_lrdy", {63'd0, lsu_index_ready}, 64'd1);
        cyc();
        lsu_index_valid     = 1'b0;
        tbus_index_ready    = 1'b1;
        tbus_operation_done = 1'b1;
        tbus_read_data      = 64'h77;
        settle();
        check_eq("fl_next_ldone", {63'd0, lsu_operation_done}, 64'd1);
        check_eq("fl_next_ldata", lsu_read_data, 64'h77);
        cyc();
        tbus_index_ready    = 1'b0;
        tbus_operation_done = 1'b0;
        tbus_read_data      = '0;

        // ---- reset asserted in RESP ----
        lsu_index_valid = 1'b1;
        lsu_index       = 64'h5000;
        lsu_write_data  = 64'h99;
        settle();
        check_eq("rs_lrdy", {63'd0, lsu_index_ready}, 64'd1);
        cyc();
        lsu_index_valid  = 1'b0;
        tbus_index_ready = 1'b1;
        cyc();
        tbus_index_ready = 1'b0;
        reset            = 1'b1;
        settle();
        check_eq("rs_state_resp", {62'd0, dbg_state}, 64'd2);
        cyc();
        reset = 1'b0;
        settle();
        check_idle_outputs("rs_after");
        check_eq("rs_tidx", tbus_index, 64'd0);
        check_eq("rs_twdata", tbus_write_data, 64'd0);
        check_eq("rs_rdy", {62'd0, lsu_index_ready, ifu_index_ready}, 64'd0);
        cyc();
        tbus_operation_done = 1'b1;
        tbus_read_data      = 64'hBAD;
        settle();
        check_eq("rs_late_ldone", {63'd0, lsu_operation_done}, 64'd0);
        check_eq("rs_late_idone", {63'd0, ifu_operation_done}, 64'd0);
        check_eq("rs_late_ldata", lsu_read_data, 64'd0);
        cyc();
        tbus_operation_done = 1'b0;
        tbus_read_data      = '0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tbus_arbiter.md
# tbus_arbiter

Two-master arbiter for the single trinity bus (tbus) port toward L1 D$/memory. It shares the port between the LSU data channel (port 0) and the instruction-fetch channel (port 1). It latches one request at a time, drives it downstream, and routes the completion back to the owning requester. It sits between backend/frontend and the memory side, and keeps all tbus signalling semantics unchanged.

## Interface
- `ADDR_W`, default 64: width of `*_index`.
- `DATA_W`, default 64: width of write data, read data and write mask.
- `clock` in 1: single clock domain.
- `reset` in 1: synchronous, active-high.
- `lsu_index_valid` in 1: LSU request valid; must hold stable until accepted.
- `lsu_index_ready` out 1: LSU request accepted this cycle.
- `lsu_index` in ADDR_W: LSU address.
- `lsu_write_data` in DATA_W: LSU store data.
- `lsu_write_mask` in DATA_W: LSU store mask.
- `lsu_operation_type` in `TBUS_RANGE`: LSU read or write.
- `lsu_read_data` out DATA_W: read data returned to LSU.
- `lsu_operation_done` out 1: one-cycle completion pulse to LSU.
- `ifu_index_valid`, `ifu_index_ready`, `ifu_index`, `ifu_read_data`, `ifu_operation_done`: same meanings as the LSU port. The IFU port is read-only; its operation type is forced to `` `TBUS_READ ``.
- `ifu_flush` in 1: redirect; discards a pending IFU completion.
- `tbus_index_valid` out 1, `tbus_index_ready` in 1, `tbus_index` out ADDR_W, `tbus_write_data` out DATA_W, `tbus_write_mask` out DATA_W, `tbus_operation_type` out `TBUS_RANGE`, `tbus_read_data` in DATA_W, `tbus_operation_done` in 1: the downstream tbus master port.
- `arb_busy` out 1: high whenever state ≠ IDLE.

## Operation
- FSM has three states: IDLE, REQ, RESP.
- **IDLE**
  - Pick a winner among valid requesters.
  - Assert only the winner's `*_index_ready`, combinationally, in the same cycle.
  - Capture index, data, mask and type into holding registers; record the owner; go to REQ.
  - If no requester is valid, stay in IDLE.
- **REQ**
  - `tbus_index_valid`=1 and downstream outputs come from the holding registers; they are stable until the handshake.
  - On `tbus_index_ready`, go to RESP.
  - If `tbus_operation_done` arrives in the same cycle as `tbus_index_ready`, treat it as completion and go directly to IDLE.
- **RESP**
  - `tbus_index_valid`=0.
  - On `tbus_operation_done`, pulse the owner's `*_operation_done` and pass `tbus_read_data` to the owner's `*_read_data` combinationally; go to IDLE.
- Completion pulses and read data go only to the owner; the non-owner sees done=0 and read_data=0.
- **Flush**
  - If `ifu_flush` is asserted while the IFU owns a transaction (REQ or RESP), set a drop flag.
  - The downstream transaction still completes normally; it is never aborted.
  - While the drop flag is set, `ifu_operation_done` is suppressed.
  - The flag clears when the arbiter returns to IDLE.
  - `ifu_flush` in IDLE has no effect; a same-cycle IFU acceptance proceeds.
- `lsu_index_ready` and `ifu_index_ready` are never high in the same cycle. No new request is accepted outside IDLE.

## Timing
- Request accepted in cycle 0 → `tbus_index_valid` high from cycle 1.
- Completion at cycle N → requester done pulse in cycle N → FSM in IDLE at N+1; next acceptance is possible at N+1.
- Minimum occupancy: 2 cycles per transaction (accept, then REQ with same-cycle ready and done).
- Reset values: state IDLE; `tbus_index_valid`=0; all ready and done outputs 0; holding registers 0; owner=LSU; drop flag 0; round-robin pointer favours LSU; `arb_busy`=0.
- Reset asserted mid-transaction returns the FSM to IDLE on the next edge and drops any pending completion. The downstream side is also reset by the same signal.

## Configuration
- `TBUS_ARB_RR_EN` defined: round-robin arbitration.
  - When both ports request in IDLE, grant the port not served by the most recent grant.
  - The pointer updates on every acceptance.
- `TBUS_ARB_RR_EN` undefined: fixed priority, LSU over IFU. The pointer logic is absent.

## Test plan
- Single LSU read, index 0x80001000: `lsu_index_ready` in cycle 0; `tbus_index_valid` in cycle 1. Downstream ready in cycle 2, done with data 0xDEADBEEF in cycle 4 → `lsu_operation_done`=1 and `lsu_read_data`=0xDEADBEEF in cycle 4; `arb_busy`=0 in cycle 5.
- LSU store, mask 0xFF, data 0x1234: downstream sees write type, mask 0xFF and data 0x1234 stable throughout REQ, including 3 cycles of ready=0.
- Both ports valid in cycle 0:
  - Fixed priority: LSU, then LSU again if it re-requests.
  - With `TBUS_ARB_RR_EN`: LSU, then IFU, then LSU across three back-to-back transactions.
- IFU read with `ifu_flush` in RESP: downstream done still consumed; `ifu_operation_done` stays 0; next LSU request is accepted the cycle after done.
- `tbus_index_ready` and `tbus_operation_done` in the same cycle in REQ → owner done in that cycle, IDLE next cycle.
- `reset` asserted while in RESP → next cycle: IDLE, all outputs 0; a later downstream done produces no requester pulse.
